// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: LOAD/SLL/SRL/SRA/ROR/ROL on a 32-bit operand, one bit per clock.
// Latency: shamt=N>0 -> done N cycles after the start edge; shamt=0 or LOAD/NOP -> done right after it.
// No backpressure: start is honoured only in IDLE; requests while busy or done are dropped.
// Build option: define SHIFT_UNIT_FAST_EN for a single-cycle barrel implementation (same results).
module shift_unit_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         shift_op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   data_in,
   output logic [WIDTH-1:0]   data_out,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_SRL  = 3'b011;
   localparam logic [2:0] OP_SRA  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ROL  = 3'b110;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q,  data_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [2:0]         op_q,    op_d;

   // True for the opcodes that actually move bits; LOAD and NOP only capture the operand.
   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
             (op == OP_ROR) || (op == OP_ROL);
   endfunction

   // One-bit step applied per SHIFT cycle.
   function automatic logic [WIDTH-1:0] step(input logic [2:0] op, input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = d;
      case (op)
         OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
         OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
         OP_ROR:  r = {d[0], d[WIDTH-1:1]};
         OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
         default: r = d;
      endcase
      return r;
   endfunction

`ifdef SHIFT_UNIT_FAST_EN
   // Whole shift in one go; rotates use a doubled operand so the wrap-around falls out naturally.
   function automatic logic [WIDTH-1:0] barrel(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                              input logic [SHAMT_W-1:0] n);
      logic [WIDTH-1:0]   r;
      logic [2*WIDTH-1:0] dd;
      r  = d;
      dd = {d, d};
      case (op)
         OP_SLL:  r = d << n;
         OP_SRL:  r = d >> n;
         OP_SRA:  r = $unsigned($signed(d) >>> n);
         OP_ROR:  begin dd = dd >> n; r = dd[WIDTH-1:0]; end
         OP_ROL:  begin dd = dd << n; r = dd[2*WIDTH-1:WIDTH]; end
         default: r = d;
      endcase
      return r;
   endfunction
`endif

   // State and datapath registers; reset aborts any operation without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         count_q <= '0;
         op_q    <= OP_NOP;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
         op_q    <= op_d;
      end
   end

   // Next-state logic: accept in IDLE, step in SHIFT, single-cycle DONE back to IDLE.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = shift_op;
               count_d = shamt;
`ifdef SHIFT_UNIT_FAST_EN
               data_d  = barrel(shift_op, data_in, shamt);
               state_d = S_DONE;
`else
               data_d  = data_in;
               if ((shamt == '0) || !is_shift(shift_op)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
`endif
            end
         end
         S_SHIFT: begin
            data_d  = step(op_q, data_q);
            count_d = count_q - 1'b1;
            // count is at least 1 on entry, so leaving at 1 means it never wraps
            if (count_q == SHAMT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign data_out = data_q;
   assign busy     = (state_q == S_SHIFT);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: reset, every shift op, boundaries, ignored starts.
// Expected values are hand-computed constants; latency expectations follow the build option.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
module tb_shift_unit_seq;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_SRL  = 3'b011;
   localparam logic [2:0] OP_SRA  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ROL  = 3'b110;

`ifdef SHIFT_UNIT_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  shift_op;
   logic [4:0]  shamt;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   int          n_vec = 0;
   int          n_err = 0;

   int          r_lat;
   int          r_busy;
   logic        r_overlap;
   logic [31:0] r_dat;

   shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .shift_op (shift_op),
      .shamt    (shamt),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Issue one request and follow it to done; r_lat counts edges after the start edge.
   task automatic run_op(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] d);
      @(negedge clk);
      start = 1'b1; shift_op = op; shamt = amt; data_in = d;
      @(negedge clk);
      start = 1'b0; shift_op = OP_NOP; shamt = 5'd0; data_in = 32'h0;
      r_lat = 0; r_busy = 0; r_overlap = 1'b0;
      while (done !== 1'b1 && r_lat < 100) begin
         if (busy === 1'b1) r_busy++;
         @(negedge clk);
         r_lat++;
      end
      if (busy === 1'b1 && done === 1'b1) r_overlap = 1'b1;
      r_dat = data_out;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; shift_op = OP_NOP; shamt = 5'd0; data_in = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++; if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=%h", data_out, 32'h0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_shift();
      logic seen_done;
      @(negedge clk);
      start = 1'b1; shift_op = OP_SLL; shamt = 5'd20; data_in = 32'h1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++; if (data_out !== 32'h0) begin n_err++; $display("FAIL midrst_data got=%h exp=%h", data_out, 32'h0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
      seen_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1'b1;
      end
      n_vec++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL midrst_late_done got=%b exp=0", seen_done); end
   endtask

   task automatic test_sll();
      run_op(OP_SLL, 5'd4, 32'h0000_0001);
      n_vec++; if (r_lat != (FAST ? 0 : 4)) begin n_err++; $display("FAIL sll_latency got=%0d exp=%0d", r_lat, FAST ? 0 : 4); end
      n_vec++; if (r_busy != (FAST ? 0 : 4)) begin n_err++; $display("FAIL sll_busy_cycles got=%0d exp=%0d", r_busy, FAST ? 0 : 4); end
      n_vec++; if (r_dat !== 32'h0000_0010) begin n_err++; $display("FAIL sll_data got=%h exp=%h", r_dat, 32'h0000_0010); end
      n_vec++; if (r_overlap !== 1'b0) begin n_err++; $display("FAIL sll_busy_done_overlap got=%b exp=0", r_overlap); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL sll_done_width got=%b exp=0", done); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sll_idle_busy got=%b exp=0", busy); end
      n_vec++; if (data_out !== 32'h0000_0010) begin n_err++; $display("FAIL sll_hold got=%h exp=%h", data_out, 32'h0000_0010); end
   endtask

   task automatic test_max_shift();
      run_op(OP_SRA, 5'd31, 32'h8000_0000);
      n_vec++; if (r_lat != (FAST ? 0 : 31)) begin n_err++; $display("FAIL sra31_latency got=%0d exp=%0d", r_lat, FAST ? 0 : 31); end
      n_vec++; if (r_busy != (FAST ? 0 : 31)) begin n_err++; $display("FAIL sra31_busy_cycles got=%0d exp=%0d", r_busy, FAST ? 0 : 31); end
      n_vec++; if (r_dat !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sra31_data got=%h exp=%h", r_dat, 32'hFFFF_FFFF); end
      run_op(OP_SRL, 5'd31, 32'h8000_0000);
      n_vec++; if (r_lat != (FAST ? 0 : 31)) begin n_err++; $display("FAIL srl31_latency got=%0d exp=%0d", r_lat, FAST ? 0 : 31); end
      n_vec++; if (r_dat !== 32'h0000_0001) begin n_err++; $display("FAIL srl31_data got=%h exp=%h", r_dat, 32'h0000_0001); end
   endtask

   task automatic test_rotates();
      run_op(OP_ROR, 5'd8, 32'h1234_5678);
      n_vec++; if (r_dat !== 32'h7812_3456) begin n_err++; $display("FAIL ror8_data got=%h exp=%h", r_dat, 32'h7812_3456); end
      n_vec++; if (r_lat != (FAST ? 0 : 8)) begin n_err++; $display("FAIL ror8_latency got=%0d exp=%0d", r_lat, FAST ? 0 : 8); end
      run_op(OP_ROL, 5'd8, 32'h1234_5678);
      n_vec++; if (r_dat !== 32'h3456_7812) begin n_err++; $display("FAIL rol8_data got=%h exp=%h", r_dat, 32'h3456_7812); end
      run_op(OP_SLL, 5'd1, 32'h8000_0001);
      n_vec++; if (r_dat !== 32'h0000_0002) begin n_err++; $display("FAIL sll1_data got=%h exp=%h", r_dat, 32'h0000_0002); end
      n_vec++; if (r_lat != (FAST ? 0 : 1)) begin n_err++; $display("FAIL sll1_latency got=%0d exp=%0d", r_lat, FAST ? 0 : 1); end
   endtask

   task automatic test_zero_and_load();
      run_op(OP_SRL, 5'd0, 32'hDEAD_BEEF);
      n_vec++; if (r_lat != 0) begin n_err++; $display("FAIL srl0_latency got=%0d exp=0", r_lat); end
      n_vec++; if (r_busy != 0) begin n_err++; $display("FAIL srl0_busy_cycles got=%0d exp=0", r_busy); end
      n_vec++; if (r_dat !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL srl0_data got=%h exp=%h", r_dat, 32'hDEAD_BEEF); end
      run_op(OP_LOAD, 5'd7, 32'hDEAD_BEEF);
      n_vec++; if (r_lat != 0) begin n_err++; $display("FAIL load_latency got=%0d exp=0", r_lat); end
      n_vec++; if (r_busy != 0) begin n_err++; $display("FAIL load_busy_cycles got=%0d exp=0", r_busy); end
      n_vec++; if (r_dat !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_data got=%h exp=%h", r_dat, 32'hDEAD_BEEF); end
      run_op(3'b111, 5'd9, 32'h0BAD_F00D);
      n_vec++; if (r_lat != 0) begin n_err++; $display("FAIL nop_latency got=%0d exp=0", r_lat); end
      n_vec++; if (r_dat !== 32'h0BAD_F00D) begin n_err++; $display("FAIL nop_data got=%h exp=%h", r_dat, 32'h0BAD_F00D); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      start = 1'b1; shift_op = OP_SLL; shamt = 5'd3; data_in = 32'h0000_0001;
      @(negedge clk);
      start = 1'b0; shift_op = OP_NOP; shamt = 5'd0; data_in = 32'h0;
`ifdef SHIFT_UNIT_FAST_EN
      // unit is in DONE here; a new request across the next edge must be dropped
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got=%b exp=1", done); end
      n_vec++; if (data_out !== 32'h0000_0008) begin n_err++; $display("FAIL b2b_first_data got=%h exp=%h", data_out, 32'h0000_0008); end
      start = 1'b1; shift_op = OP_SRL; shamt = 5'd3; data_in = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0; shift_op = OP_NOP; shamt = 5'd0; data_in = 32'h0;
      repeat (2) @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_second_done got=%b exp=0", done); end
      n_vec++; if (data_out !== 32'h0000_0008) begin n_err++; $display("FAIL b2b_result got=%h exp=%h", data_out, 32'h0000_0008); end
`else
      @(negedge clk);
      // second request straddles edge 2 while the first is still shifting
      start = 1'b1; shift_op = OP_SRL; shamt = 5'd3; data_in = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0; shift_op = OP_NOP; shamt = 5'd0; data_in = 32'h0;
      lat = 2;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
      n_vec++; if (data_out !== 32'h0000_0008) begin n_err++; $display("FAIL b2b_result got=%h exp=%h", data_out, 32'h0000_0008); end
      repeat (2) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_no_restart got=%b exp=0", busy); end
      n_vec++; if (data_out !== 32'h0000_0008) begin n_err++; $display("FAIL b2b_hold got=%h exp=%h", data_out, 32'h0000_0008); end
`endif
   endtask

   initial begin
      test_reset();
      test_reset_mid_shift();
      test_sll();
      test_max_shift();
      test_rotates();
      test_zero_and_load();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
